irq_ctrl: RTL and testbench

- Interrupt controller on the CPU-facing side of the core's interrupt interface.
- Synchronises and edge-detects external interrupt lines and latches them as pending.
- Presents one prioritised request (irq_o, irq_num_o) to the instruction decoder and holds it until the core acknowledges vectoring.
- Returns to idle on the decoder's end-of-interrupt pulse (eoi, raised by SRET/MRET). Only one interrupt is in service at a time; there is no nesting.

---
 rtl/irq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised interrupt request controller with single-level service
//
// Synchronises and edge-detects external interrupt lines, latches them as pending,
// presents one lowest-index-wins request to the decoder and holds it through service.
//
// Ports:
//   clk           system clock
//   reset_i       synchronous active-high reset
//   irq_lines_i   asynchronous interrupt sources, rising-edge triggered
//   global_en_i   master interrupt enable
//   mask_i        per-line enable (1 = enabled)
//   ack_i         core has vectored to the presented interrupt (one-cycle pulse)
//   eoi_i         end of interrupt from decoder (SRET/MRET pulse)
//   irq_o         request to decoder
//   irq_num_o     number of the requested / in-service interrupt
//   pending_o     latched pending bits
//   in_service_o  high while a handler is running

module irq_ctrl #(
   parameter int NUM_IRQ     = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset_i,
   input  logic [NUM_IRQ-1:0]         irq_lines_i,
   input  logic                       global_en_i,
   input  logic [NUM_IRQ-1:0]         mask_i,
   input  logic                       ack_i,
   input  logic                       eoi_i,
   output logic                       irq_o,
   output logic [$clog2(NUM_IRQ)-1:0] irq_num_o,
   output logic [NUM_IRQ-1:0]         pending_o,
   output logic                       in_service_o
);

   localparam int IW = $clog2(NUM_IRQ);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      num_q, num_d;
   logic [NUM_IRQ-1:0] pend_q, pend_d;

   logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0] sync_out;
   logic [NUM_IRQ-1:0] prev_q;
   logic [NUM_IRQ-1:0] armed_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic               flushed;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] elig;
   logic [IW-1:0]      win;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // fill_q walks a 1 through after reset; once it reaches the end the
   // synchroniser output reflects a genuine sample of the line.
   assign flushed = fill_q[SYNC_STAGES-1];

   // A line only counts as rising once it has been seen low after reset, so a
   // level held high across reset does not look like a fresh edge.
   assign rise = sync_out & ~prev_q & armed_q;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q  <= '0;
         armed_q <= '0;
         fill_q  <= '0;
      end else begin
         sync_q[0] <= irq_lines_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q  <= sync_out;
         fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         armed_q <= armed_q | ({NUM_IRQ{flushed}} & ~sync_out);
      end
   end

   // Pending: clear the acknowledged line, then OR in new edges so a
   // simultaneous rise on that same line survives the ack.
   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if ((state_q == ST_REQ) && ack_i && (num_q == IW'(i))) begin
            clr[i] = 1'b1;
         end
      end
      pend_d = (pend_q & ~clr) | rise;
   end

   assign elig = global_en_i ? (pend_q & mask_i) : '0;

   // Lowest index wins: scan downwards so the last hit is the smallest.
   always_comb begin
      win = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win = IW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         num_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         pend_q  <= pend_d;
      end
   end

   // Request number is latched only when leaving IDLE; REQ and SERVICE never
   // re-arbitrate, and enables are not consulted once a request is up.
   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      irq_o        = 1'b0;
      in_service_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (elig != '0) begin
               state_d = ST_REQ;
               num_d   = win;
            end
         end
         ST_REQ: begin
            irq_o = 1'b1;
            if (ack_i) begin
               state_d = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            in_service_o = 1'b1;
            if (eoi_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign irq_num_o = num_q;
   assign pending_o = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed scoreboard bench for irq_ctrl

module tb_irq_ctrl;

   localparam int F_IRQ  = 0;
   localparam int F_NUM  = 1;
   localparam int F_PEND = 2;
   localparam int F_IS   = 3;

   logic       clk = 1'b0;
   logic       reset_i;
   logic [1:0] irq_lines_i;
   logic       global_en_i;
   logic [1:0] mask_i;
   logic       ack_i;
   logic       eoi_i;
   logic       irq_o;
   logic [0:0] irq_num_o;
   logic [1:0] pending_o;
   logic       in_service_o;

   irq_ctrl #(.NUM_IRQ(2), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .irq_lines_i  (irq_lines_i),
      .global_en_i  (global_en_i),
      .mask_i       (mask_i),
      .ack_i        (ack_i),
      .eoi_i        (eoi_i),
      .irq_o        (irq_o),
      .irq_num_o    (irq_num_o),
      .pending_o    (pending_o),
      .in_service_o (in_service_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      string       tag;
      int          fld;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] observe(input int fld);
      logic [31:0] v;
      v = '0;
      case (fld)
         F_IRQ:   v = {31'd0, irq_o};
         F_NUM:   v = {31'd0, irq_num_o};
         F_PEND:  v = {30'd0, pending_o};
         default: v = {31'd0, in_service_o};
      endcase
      return v;
   endfunction

   // Queue an expectation for the sample point dly edges from now, kept sorted by due cycle.
   task automatic expect_at(input int dly, input string tag, input int fld, input logic [31:0] val);
      exp_t e;
      int   idx;
      e.due = cyc + dly;
      e.tag = tag;
      e.fld = fld;
      e.exp = val;
      idx = sb.size();
      for (int j = 0; j < sb.size(); j++) begin
         if (sb[j].due > e.due) begin
            idx = j;
            break;
         end
      end
      sb.insert(idx, e);
   endtask

   task automatic tick();
      exp_t        e;
      logic [31:0] obs;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e   = sb.pop_front();
         obs = observe(e.fld);
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at cycle %0d", e.tag, obs, e.exp, cyc);
         end
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i     = 1'b1;
      irq_lines_i = 2'b00;
      global_en_i = 1'b0;
      mask_i      = 2'b00;
      ack_i       = 1'b0;
      eoi_i       = 1'b0;

      // reset state
      expect_at(2, "rst_irq",  F_IRQ,  0);
      expect_at(2, "rst_num",  F_NUM,  0);
      expect_at(2, "rst_pend", F_PEND, 0);
      expect_at(2, "rst_is",   F_IS,   0);
      ticks(2);
      reset_i = 1'b0;
      ticks(4);

      // basic: line0 high for 5 cycles
      mask_i = 2'b11; global_en_i = 1'b1; irq_lines_i = 2'b01;
      expect_at(3, "basic_pend_k2", F_PEND, 2'b01);
      expect_at(3, "basic_irq_k2",  F_IRQ,  0);
      expect_at(4, "basic_irq_k3",  F_IRQ,  1);
      expect_at(4, "basic_num_k3",  F_NUM,  0);
      ticks(5);
      irq_lines_i = 2'b00;
      ticks(1);
      ack_i = 1'b1;
      expect_at(1, "basic_ack_pend", F_PEND, 2'b00);
      expect_at(1, "basic_ack_is",   F_IS,   1);
      expect_at(1, "basic_ack_irq",  F_IRQ,  0);
      ticks(1);
      ack_i = 1'b0;
      ticks(2);
      eoi_i = 1'b1;
      expect_at(1, "basic_eoi_is",    F_IS,  0);
      expect_at(3, "basic_one_rise",  F_IRQ, 0);
      ticks(1);
      eoi_i = 1'b0;
      ticks(3);

      // priority: both lines rise together
      irq_lines_i = 2'b11;
      expect_at(3, "prio_pend", F_PEND, 2'b11);
      expect_at(4, "prio_irq",  F_IRQ,  1);
      expect_at(4, "prio_num0", F_NUM,  0);
      ticks(5);
      irq_lines_i = 2'b00;
      ack_i = 1'b1;
      expect_at(1, "prio_ack_pend", F_PEND, 2'b10);
      expect_at(1, "prio_ack_is",   F_IS,   1);
      ticks(1);
      ack_i = 1'b0;
      eoi_i = 1'b1;
      expect_at(1, "prio_gap_irq", F_IRQ, 0);
      expect_at(1, "prio_gap_is",  F_IS,  0);
      expect_at(2, "prio_irq2",    F_IRQ, 1);
      expect_at(2, "prio_num1",    F_NUM, 1);
      ticks(1);
      eoi_i = 1'b0;
      ticks(1);
      // stray eoi while requesting
      eoi_i = 1'b1;
      expect_at(1, "eoi_req_irq", F_IRQ, 1);
      expect_at(1, "eoi_req_num", F_NUM, 1);
      expect_at(1, "eoi_req_is",  F_IS,  0);
      ticks(1);
      eoi_i = 1'b0;
      ack_i = 1'b1;
      expect_at(1, "prio2_ack_pend", F_PEND, 2'b00);
      expect_at(1, "prio2_ack_is",   F_IS,   1);
      ticks(1);
      ack_i = 1'b0;
      eoi_i = 1'b1;
      expect_at(1, "prio2_eoi_is", F_IS, 0);
      ticks(1);
      eoi_i = 1'b0;
      ticks(2);

      // stray eoi in idle
      eoi_i = 1'b1;
      expect_at(1, "eoi_idle_irq",  F_IRQ,  0);
      expect_at(1, "eoi_idle_is",   F_IS,   0);
      expect_at(1, "eoi_idle_pend", F_PEND, 2'b00);
      ticks(1);
      eoi_i = 1'b0;
      ticks(1);

      // mask memory
      mask_i = 2'b00; irq_lines_i = 2'b10;
      expect_at(3, "mask_pend",  F_PEND, 2'b10);
      expect_at(5, "mask_noirq", F_IRQ,  0);
      ticks(5);
      irq_lines_i = 2'b00; mask_i = 2'b10;
      expect_at(1, "mask_irq", F_IRQ, 1);
      expect_at(1, "mask_num", F_NUM, 1);
      ticks(1);
      mask_i = 2'b00; global_en_i = 1'b0;
      expect_at(2, "req_hold_irq", F_IRQ, 1);
      ticks(2);
      ack_i = 1'b1;
      expect_at(1, "mask_ack_is",   F_IS,   1);
      expect_at(1, "mask_ack_pend", F_PEND, 2'b00);
      ticks(1);
      ack_i = 1'b0; mask_i = 2'b11; global_en_i = 1'b1; irq_lines_i = 2'b10;
      expect_at(3, "svc_rise_pend", F_PEND, 2'b10);
      ticks(3);
      // stray ack in service
      ack_i = 1'b1;
      expect_at(1, "ack_svc_pend", F_PEND, 2'b10);
      expect_at(1, "ack_svc_is",   F_IS,   1);
      expect_at(1, "ack_svc_irq",  F_IRQ,  0);
      ticks(1);
      ack_i = 1'b0; irq_lines_i = 2'b00; eoi_i = 1'b1;
      expect_at(1, "svc_eoi_is",  F_IS,  0);
      expect_at(2, "resvc_irq",   F_IRQ, 1);
      expect_at(2, "resvc_num",   F_NUM, 1);
      ticks(1);
      eoi_i = 1'b0;
      ticks(1);
      ack_i = 1'b1;
      expect_at(1, "resvc_ack_pend", F_PEND, 2'b00);
      ticks(1);
      ack_i = 1'b0; eoi_i = 1'b1;
      expect_at(1, "resvc_eoi_is", F_IS, 0);
      ticks(1);
      eoi_i = 1'b0;
      ticks(3);

      // set/clear collision on line0
      irq_lines_i = 2'b01;
      expect_at(3, "coll_pend", F_PEND, 2'b01);
      expect_at(4, "coll_irq",  F_IRQ,  1);
      expect_at(4, "coll_num",  F_NUM,  0);
      ticks(4);
      irq_lines_i = 2'b00;
      ticks(2);
      irq_lines_i = 2'b01;
      ticks(2);
      ack_i = 1'b1;
      expect_at(1, "coll_set_wins", F_PEND, 2'b01);
      expect_at(1, "coll_is",       F_IS,   1);
      expect_at(1, "coll_irq_low",  F_IRQ,  0);
      ticks(1);
      ack_i = 1'b0;
      ticks(1);
      eoi_i = 1'b1;
      expect_at(1, "coll_eoi_is", F_IS,  0);
      expect_at(2, "coll_irq2",   F_IRQ, 1);
      expect_at(2, "coll_num2",   F_NUM, 0);
      ticks(1);
      eoi_i = 1'b0;
      ticks(1);
      ack_i = 1'b1;
      expect_at(1, "coll2_ack_pend", F_PEND, 2'b00);
      expect_at(1, "coll2_ack_is",   F_IS,   1);
      ticks(1);
      ack_i = 1'b0; irq_lines_i = 2'b11;
      expect_at(3, "pre_rst_pend", F_PEND, 2'b10);
      expect_at(3, "pre_rst_is",   F_IS,   1);
      ticks(3);

      // reset mid-service with line1 pending, lines held high
      reset_i = 1'b1;
      expect_at(1, "mrst_irq",  F_IRQ,  0);
      expect_at(1, "mrst_num",  F_NUM,  0);
      expect_at(1, "mrst_pend", F_PEND, 2'b00);
      expect_at(1, "mrst_is",   F_IS,   0);
      ticks(1);
      reset_i = 1'b0;
      expect_at(5, "held_no_pend", F_PEND, 2'b00);
      expect_at(5, "held_no_irq",  F_IRQ,  0);
      expect_at(6, "held_no_pend2", F_PEND, 2'b00);
      ticks(6);
      irq_lines_i = 2'b00;
      ticks(4);
      irq_lines_i = 2'b01;
      expect_at(3, "rerise_pend", F_PEND, 2'b01);
      expect_at(4, "rerise_irq",  F_IRQ,  1);
      expect_at(4, "rerise_num",  F_NUM,  0);
      ticks(5);
      ticks(2);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed=%0d expected=0 outstanding entries", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
